fpu_scheduler: RTL and testbench
================================

# fpu_scheduler

Multicycle issue controller that shares the single combinational `fpu` datapath between two requesters, e.g. the CPU FP pipeline and a neuron-update engine. It arbitrates round-robin, registers the winning request's operands and operation code, and holds them on the FPU inputs for a fixed settle window. It then captures the FPU result and returns it on a shared response channel with valid/ready backpressure. Unimplemented operation codes are rejected with an error flag without occupying the settle window.

## Interface
- `LATENCY`, default 3: cycles the FPU inputs are held before the result is sampled. Legal range 1..255.

- `CLK`  in  1  clock, all state on rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `REQ0_VALID`  in  1  requester 0 has an operation
- `REQ0_READY`  out  1  requester 0 operation accepted this cycle
- `REQ0_DATA1`, `REQ0_DATA2`, `REQ0_DATA3`  in  32 each  requester 0 operands
- `REQ0_SELECT`  in  5  requester 0 FPU operation code
- `REQ1_VALID`, `REQ1_READY`, `REQ1_DATA1..3`, `REQ1_SELECT`  same as requester 0, for requester 1
- `RESP_VALID`  out  1  response available
- `RESP_READY`  in  1  consumer accepts response
- `RESP_ID`  out  1  requester that owns the response
- `RESP_RESULT`  out  32  FPU result
- `RESP_ERR`  out  1  operation code was rejected; `RESP_RESULT` is 0
- `FPU_DATA1`, `FPU_DATA2`, `FPU_DATA3`  out  32 each  to the FPU
- `FPU_SELECT`  out  5  to the FPU
- `FPU_RESULT`  in  32  from the FPU
- `BUSY`  out  1  state is not IDLE

## Operation
- State machine:
  - IDLE → EXEC when a legal code is granted.
  - IDLE → RESP when an illegal code is granted.
  - EXEC → RESP when the counter reaches 0.
  - RESP → IDLE on `RESP_VALID & RESP_READY`.
- Arbitration runs in IDLE only.
  - One requester valid: it is granted.
  - Both valid: the requester named by the `PRIO` bit is granted.
  - `REQi_READY` is combinational: high only in IDLE for the granted requester. At most one READY is high per cycle.
- On accept, `DATA1..3`, `SELECT` and the requester ID are registered into operand and ID registers.
- Legal codes: 00000–01100 and 01110–10010.
- Illegal codes: 01101 (FSQRT), 10011 (FCVTWUS), 10100 (FCLASS) and every code at or above 10101.
  - Result register is loaded with 0 and the error register with 1.
  - State goes directly to RESP.
- EXEC:
  - The 8-bit counter loads `LATENCY-1` on accept.
  - It decrements every EXEC cycle.
  - In the EXEC cycle where counter == 0, `FPU_RESULT` is captured into the result register, error register ← 0, next state RESP.
- `FPU_*` are driven from the operand registers in EXEC and RESP. In IDLE they are zero (`FPU_SELECT` = 00000, forward).
- RESP:
  - `RESP_VALID` = 1; `RESP_ID`, `RESP_RESULT` and `RESP_ERR` are driven from registers.
  - All four are held stable until the handshake.
  - On the handshake, `PRIO` ← inverse of the served ID.
- No operation is accepted while `BUSY` is high; requesters stall on READY.
- Reset values: state IDLE, `PRIO` 0, counter 0, operand/result/ID/error registers 0. All outputs are 0, except that `REQ0_READY`/`REQ1_READY` follow the IDLE arbitration while RESET is low.

## Timing
- Accept in cycle T (IDLE, VALID & READY).
- Legal op: EXEC in cycles T+1..T+LATENCY; `RESP_VALID` rises at T+LATENCY+1.
- Illegal op: `RESP_VALID` at T+1.
- With `RESP_READY` held high, IDLE is re-entered at T+LATENCY+2. The next accept is possible in that cycle, giving peak throughput of one op per LATENCY+2 cycles.
- The result is sampled exactly LATENCY cycles after the operands first appear on `FPU_*`, which is the multicycle-path budget for the FPU.
- Simultaneous VALID in IDLE: only the `PRIO` winner sees READY. The loser must hold VALID and operands stable and is served next, because `PRIO` flips after every response.
- VALID may drop before READY without effect; requesters hold operands stable while VALID is high.
- `RESP_READY` low: stay in RESP indefinitely with the response stable; no new accept.
- RESET asserted in any state clears immediately (asynchronously). Any in-flight operation or unconsumed response is discarded. The first accept is possible on the first rising edge after RESET falls.

## Test plan
- **Single add:** LATENCY=3, REQ0 FADD (00001), 0x3F800000 + 0x40000000 → `REQ0_READY` at T, `RESP_VALID` at T+4, `RESP_ID`=0, `RESP_RESULT`=0x40400000, `RESP_ERR`=0.
- **Contention:** both request FMUL (00011) 0x40000000 × 0x40400000 in the same cycle after reset → REQ0 is served first with 0x40C00000; REQ1 is accepted in the cycle IDLE is re-entered and gets 0x40C00000 with `RESP_ID`=1. The next simultaneous pair serves REQ0 again.
- **Fused:** REQ1 FMADD (01110), 0x40000000, 0x40400000, 0x3F800000 → `RESP_RESULT`=0x40E00000. `FPU_SELECT`=01110 is held for all 3 EXEC cycles.
- **Illegal code:** REQ0 SELECT=01101 → `RESP_VALID` at T+1, `RESP_ERR`=1, `RESP_RESULT`=0. SELECT=11111 gives the same result.
- **Backpressure:** `RESP_READY` low for 10 cycles → `RESP_*` stable throughout, `BUSY`=1, no READY to REQ1 while REQ1_VALID=1; REQ1 is accepted the cycle after the handshake.
- **Reset mid-EXEC:** RESET asserted during the second EXEC cycle → `BUSY`, `RESP_VALID` and `FPU_*` go to 0 immediately; no response is produced; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/fpu_scheduler.sv
// Round-robin issue controller sharing one combinational FPU between two requesters.
// Operands are held on the FPU for LATENCY cycles, then the result is returned via valid/ready.
module fpu_scheduler #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [31:0] REQ0_DATA1,
  input  logic [31:0] REQ0_DATA2,
  input  logic [31:0] REQ0_DATA3,
  input  logic [4:0]  REQ0_SELECT,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [31:0] REQ1_DATA1,
  input  logic [31:0] REQ1_DATA2,
  input  logic [31:0] REQ1_DATA3,
  input  logic [4:0]  REQ1_SELECT,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic        RESP_ID,
  output logic [31:0] RESP_RESULT,
  output logic        RESP_ERR,
  output logic [31:0] FPU_DATA1,
  output logic [31:0] FPU_DATA2,
  output logic [31:0] FPU_DATA3,
  output logic [4:0]  FPU_SELECT,
  input  logic [31:0] FPU_RESULT,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        prio;
  logic [7:0]  cnt;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] op3;
  logic [4:0]  op_sel;
  logic        id_q;
  logic [31:0] res_q;
  logic        err_q;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [31:0] acc_d1;
  logic [31:0] acc_d2;
  logic [31:0] acc_d3;
  logic [4:0]  acc_sel;
  logic        acc_legal;

  // Grant is withheld while RESET is high so no requester sees READY during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !RESET) begin
      if (REQ0_VALID && (!REQ1_VALID || !prio)) begin
        grant0 = 1'b1;
      end else if (REQ1_VALID) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    accept    = grant0 | grant1;
    acc_d1    = grant1 ? REQ1_DATA1  : REQ0_DATA1;
    acc_d2    = grant1 ? REQ1_DATA2  : REQ0_DATA2;
    acc_d3    = grant1 ? REQ1_DATA3  : REQ0_DATA3;
    acc_sel   = grant1 ? REQ1_SELECT : REQ0_SELECT;
    // FSQRT (01101) and everything from FCVTWUS (10011) upward is unimplemented.
    acc_legal = (acc_sel <= 5'd18) && (acc_sel != 5'd13);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = acc_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (RESP_READY) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prio   <= 1'b0;
      cnt    <= '0;
      op1    <= '0;
      op2    <= '0;
      op3    <= '0;
      op_sel <= '0;
      id_q   <= 1'b0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op1    <= acc_d1;
            op2    <= acc_d2;
            op3    <= acc_d3;
            op_sel <= acc_sel;
            id_q   <= grant1;
            if (acc_legal) begin
              cnt <= 8'(LATENCY - 1);
            end else begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            res_q <= FPU_RESULT;
            err_q <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (RESP_READY) begin
            prio <= ~id_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    REQ0_READY  = grant0;
    REQ1_READY  = grant1;
    BUSY        = (state != IDLE);
    RESP_VALID  = (state == RESP);
    RESP_ID     = id_q;
    RESP_RESULT = res_q;
    RESP_ERR    = err_q;
    FPU_DATA1   = BUSY ? op1    : '0;
    FPU_DATA2   = BUSY ? op2    : '0;
    FPU_DATA3   = BUSY ? op3    : '0;
    FPU_SELECT  = BUSY ? op_sel : '0;
  end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Self-checking bench for fpu_scheduler: vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_fpu_scheduler;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_d1, req0_d2, req0_d3, req1_d1, req1_d2, req1_d3;
  logic [4:0]  req0_sel, req1_sel;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [31:0] resp_result;
  logic [31:0] fpu_d1, fpu_d2, fpu_d3, fpu_result;
  logic [4:0]  fpu_sel;

  int unsigned tests = 0;
  int unsigned fails = 0;

  fpu_scheduler #(.LATENCY(LAT)) dut (
    .CLK(clk), .RESET(rst),
    .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready),
    .REQ0_DATA1(req0_d1), .REQ0_DATA2(req0_d2), .REQ0_DATA3(req0_d3), .REQ0_SELECT(req0_sel),
    .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready),
    .REQ1_DATA1(req1_d1), .REQ1_DATA2(req1_d2), .REQ1_DATA3(req1_d3), .REQ1_SELECT(req1_sel),
    .RESP_VALID(resp_valid), .RESP_READY(resp_ready), .RESP_ID(resp_id),
    .RESP_RESULT(resp_result), .RESP_ERR(resp_err),
    .FPU_DATA1(fpu_d1), .FPU_DATA2(fpu_d2), .FPU_DATA3(fpu_d3), .FPU_SELECT(fpu_sel),
    .FPU_RESULT(fpu_result), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact single-precision encode/decode for small non-negative integers.
  function automatic logic [31:0] from_int(input int unsigned n);
    int unsigned p;
    logic [31:0] m;
    logic [7:0]  e;
    if (n == 0) return '0;
    p = 0;
    for (int unsigned i = 0; i < 24; i++) if (n[i]) p = i;
    m = n << (23 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  function automatic int unsigned to_int(input logic [31:0] f);
    logic [31:0] m;
    int sh;
    if (f[30:0] == '0) return 0;
    m  = {8'd0, 1'b1, f[22:0]};
    sh = 150 - int'(f[30:23]);
    if (sh < 0 || sh > 31) return 0;
    return m >> sh;
  endfunction

  function automatic logic [31:0] fpu_fn(input logic [4:0] sel, input logic [31:0] a, b, c);
    case (sel)
      5'd1:    return from_int(to_int(a) + to_int(b));
      5'd3:    return from_int(to_int(a) * to_int(b));
      5'd14:   return from_int(to_int(a) * to_int(b) + to_int(c));
      default: return a ^ {b[15:0], b[31:16]} ^ (c + 32'(sel));
    endcase
  endfunction

  function automatic logic is_legal(input logic [4:0] sel);
    return !(sel == 5'd13 || sel >= 5'd19);
  endfunction

  // FPU stand-in: output is garbage until its inputs have been stable for LAT cycles.
  logic [100:0] fpu_prev = '0;
  int unsigned  fpu_age = 0;
  logic [100:0] fpu_cur;
  int unsigned  fpu_present;
  assign fpu_cur     = {fpu_sel, fpu_d1, fpu_d2, fpu_d3};
  assign fpu_present = (fpu_cur == fpu_prev) ? fpu_age + 1 : 1;
  assign fpu_result  = (fpu_present >= LAT) ? fpu_fn(fpu_sel, fpu_d1, fpu_d2, fpu_d3) : 32'hDEADBEEF;
  always @(posedge clk) begin
    fpu_age  <= (fpu_cur == fpu_prev) ? fpu_age + 1 : 1;
    fpu_prev <= fpu_cur;
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [4:0] sel,
                         input logic [31:0] a, b, c);
    if (id) begin
      req1_valid = v; req1_sel = sel; req1_d1 = a; req1_d2 = b; req1_d3 = c;
    end else begin
      req0_valid = v; req0_sel = sel; req0_d1 = a; req0_d2 = b; req0_d3 = c;
    end
  endtask

  // Returns the number of cycles after the accept edge at which RESP_VALID was seen.
  task automatic wait_resp(input string nm, input logic chk_r1, output int unsigned k);
    k = 1;
    while (!resp_valid && k < 64) begin
      if (chk_r1) chk1({nm, "_r1_stall"}, req1_ready, 1'b0);
      tick();
      k++;
    end
  endtask

  task automatic run_op(input string nm, input logic id, input logic [4:0] sel,
                        input logic [31:0] a, b, c, input logic [31:0] res, input logic err);
    int unsigned k;
    set_req(id, 1'b1, sel, a, b, c);
    #1;
    chk1({nm, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
    chk1({nm, "_other_ready"}, id ? req0_ready : req1_ready, 1'b0);
    tick();
    set_req(id, 1'b0, 5'd0, '0, '0, '0);
    k = 1;
    while (!resp_valid && k < 64) begin
      check32({nm, "_fpu_sel"}, 32'(fpu_sel), 32'(sel));
      tick();
      k++;
    end
    check32({nm, "_latency"}, k, err ? 1 : LAT + 1);
    chk1({nm, "_id"}, resp_id, id);
    check32({nm, "_result"}, resp_result, res);
    chk1({nm, "_err"}, resp_err, err);
    tick();
    chk1({nm, "_idle"}, busy, 1'b0);
  endtask

  typedef struct {
    logic        id;
    logic [4:0]  sel;
    logic [31:0] d1, d2, d3, res;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic id, input logic [4:0] sel, input logic [31:0] a, b, c);
    vec_t v;
    v.id = id; v.sel = sel; v.d1 = a; v.d2 = b; v.d3 = c;
    v.err = !is_legal(sel);
    v.res = v.err ? '0 : fpu_fn(sel, a, b, c);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl [10];
  logic        rv [2];
  logic [4:0]  rs [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [31:0] rc [2];

  initial begin
    int unsigned k;
    int          g;
    logic        m_idle, m_prio, m_id, m_err, exp_v;
    logic [31:0] m_res;
    int unsigned due;

    tbl[0] = '{1'b0, 5'd1,  32'h3F800000, 32'h40000000, 32'h0,        32'h40400000, 1'b0};
    tbl[1] = '{1'b1, 5'd14, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 1'b0};
    tbl[2] = '{1'b0, 5'd13, 32'h40800000, 32'h3F800000, 32'h1,        32'h0,        1'b1};
    tbl[3] = '{1'b0, 5'd31, 32'h12345678, 32'h9ABCDEF0, 32'h5,        32'h0,        1'b1};
    tbl[4] = '{1'b1, 5'd19, 32'h40000000, 32'h0,        32'h0,        32'h0,        1'b1};
    tbl[5] = '{1'b1, 5'd20, 32'hC0000000, 32'h1,        32'h2,        32'h0,        1'b1};
    tbl[6] = '{1'b0, 5'd21, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h0,        1'b1};
    tbl[7] = mk(1'b1, 5'd18, 32'hA5A5A5A5, 32'h0F0F1234, 32'h00000011);
    tbl[8] = mk(1'b0, 5'd12, 32'h11112222, 32'h33334444, 32'h55556666);
    tbl[9] = mk(1'b1, 5'd0,  32'hFFFF0000, 32'h0000FFFF, 32'h80000000);

    rst = 1'b1;
    resp_ready = 1'b1;
    set_req(1'b0, 1'b1, 5'd1, 32'h3F800000, 32'h3F800000, '0);
    set_req(1'b1, 1'b0, 5'd0, '0, '0, '0);
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_resp_result", resp_result, 32'h0);
    check32("rst_fpu_d1", fpu_d1, 32'h0);
    check32("rst_fpu_sel", 32'(fpu_sel), 32'h0);
    set_req(1'b0, 1'b0, 5'd0, '0, '0, '0);
    tick(); tick();
    rst = 1'b0;

    // Contention right after reset: REQ0 first, REQ1 next, then REQ0 again.
    set_req(1'b0, 1'b1, 5'd3, 32'h40000000, 32'h40400000, '0);
    set_req(1'b1, 1'b1, 5'd3, 32'h40000000, 32'h40400000, '0);
    #1;
    chk1("ct_ready0", req0_ready, 1'b1);
    chk1("ct_ready1", req1_ready, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 5'd0, '0, '0, '0);
    wait_resp("ct_a", 1'b1, k);
    check32("ct_a_latency", k, LAT + 1);
    chk1("ct_a_id", resp_id, 1'b0);
    check32("ct_a_result", resp_result, 32'h40C00000);
    tick();
    chk1("ct_b_ready1", req1_ready, 1'b1);
    tick();
    set_req(1'b1, 1'b0, 5'd0, '0, '0, '0);
    wait_resp("ct_b", 1'b0, k);
    check32("ct_b_latency", k, LAT + 1);
    chk1("ct_b_id", resp_id, 1'b1);
    check32("ct_b_result", resp_result, 32'h40C00000);
    tick();
    set_req(1'b0, 1'b1, 5'd3, from_int(4), from_int(5), '0);
    set_req(1'b1, 1'b1, 5'd3, from_int(6), from_int(7), '0);
    #1;
    chk1("ct_c_ready0", req0_ready, 1'b1);
    chk1("ct_c_ready1", req1_ready, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 5'd0, '0, '0, '0);
    wait_resp("ct_c", 1'b1, k);
    check32("ct_c_result", resp_result, from_int(20));
    tick();
    tick();
    set_req(1'b1, 1'b0, 5'd0, '0, '0, '0);
    wait_resp("ct_d", 1'b0, k);
    chk1("ct_d_id", resp_id, 1'b1);
    check32("ct_d_result", resp_result, from_int(42));
    tick();

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].id, tbl[i].sel, tbl[i].d1, tbl[i].d2, tbl[i].d3,
             tbl[i].res, tbl[i].err);

    // Backpressure: response held for 10 cycles while REQ1 waits.
    resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 5'd1, 32'h3F800000, 32'h40400000, '0);
    #1;
    chk1("bp_ready0", req0_ready, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 5'd0, '0, '0, '0);
    set_req(1'b1, 1'b1, 5'd3, from_int(5), from_int(7), '0);
    wait_resp("bp", 1'b1, k);
    check32("bp_latency", k, LAT + 1);
    for (int i = 0; i < 10; i++) begin
      chk1("bp_valid", resp_valid, 1'b1);
      chk1("bp_id", resp_id, 1'b0);
      check32("bp_result", resp_result, 32'h40800000);
      chk1("bp_err", resp_err, 1'b0);
      chk1("bp_busy", busy, 1'b1);
      chk1("bp_r1_stall", req1_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk1("bp_r1_ready", req1_ready, 1'b1);
    tick();
    set_req(1'b1, 1'b0, 5'd0, '0, '0, '0);
    wait_resp("bp_b", 1'b0, k);
    chk1("bp_b_id", resp_id, 1'b1);
    check32("bp_b_result", resp_result, from_int(35));
    tick();

    // Reset during the second EXEC cycle discards the operation.
    set_req(1'b0, 1'b1, 5'd1, 32'h3F800000, 32'h40000000, '0);
    #1;
    tick();
    set_req(1'b0, 1'b0, 5'd0, '0, '0, '0);
    tick();
    chk1("rx_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rx_busy", busy, 1'b0);
    chk1("rx_resp_valid", resp_valid, 1'b0);
    check32("rx_fpu_sel", 32'(fpu_sel), 32'h0);
    check32("rx_fpu_d1", fpu_d1, 32'h0);
    check32("rx_fpu_d2", fpu_d2, 32'h0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk1("rx_no_resp", resp_valid, 1'b0);
      tick();
    end
    run_op("rx_after", 1'b0, 5'd1, from_int(9), from_int(11), '0, from_int(20), 1'b0);

    // Randomized traffic against a transaction-level model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_idle = 1'b1; m_prio = 1'b0; m_id = 1'b0; m_res = '0; m_err = 1'b0; due = 0;
    rv[0] = 1'b0; rv[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rs[r] = '0; ra[r] = '0; rb[r] = '0; rc[r] = '0;
    end
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            rv[r] = 1'b1;
            rs[r] = 5'($urandom_range(0, 31));
            ra[r] = from_int($urandom_range(0, 50));
            rb[r] = from_int($urandom_range(0, 50));
            rc[r] = from_int($urandom_range(0, 50));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          rv[r] = 1'b0;
        end
        set_req(r[0], rv[r], rs[r], ra[r], rb[r], rc[r]);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (m_idle) begin
        if (rv[0] && rv[1]) g = m_prio ? 1 : 0;
        else if (rv[0]) g = 0;
        else if (rv[1]) g = 1;
      end
      chk1("rnd_ready0", req0_ready, g == 0);
      chk1("rnd_ready1", req1_ready, g == 1);
      chk1("rnd_busy", busy, !m_idle);
      exp_v = !m_idle && (cyc >= due);
      chk1("rnd_resp_valid", resp_valid, exp_v);
      if (exp_v) begin
        chk1("rnd_resp_id", resp_id, m_id);
        check32("rnd_resp_result", resp_result, m_res);
        chk1("rnd_resp_err", resp_err, m_err);
      end
      if (g >= 0) begin
        m_id   = g[0];
        m_err  = !is_legal(rs[g]);
        m_res  = m_err ? '0 : fpu_fn(rs[g], ra[g], rb[g], rc[g]);
        due    = cyc + (m_err ? 1 : LAT + 1);
        m_idle = 1'b0;
        rv[g]  = 1'b0;
      end else if (exp_v && resp_ready) begin
        m_prio = ~m_id;
        m_idle = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
